axis_uart_frame_tx: RTL and testbench



---
 rtl/axis_uart_frame_tx.sv | 139 +++++++++++++
 tb/tb_axis_uart_frame_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_frame_tx.sv
// axis_uart_frame_tx: serialises one AXI-Stream beat as a UART frame: optional header character, then payload bytes MSB byte first.
// Ports: aclk/aresetn clock and synchronous active-low reset; s_axis_tdata/tvalid/tready payload input (accepted only when idle);
//        uart_tx serial line (idle high); busy high from handshake to end of last stop bit; frame_done one-cycle pulse at frame end.
module axis_uart_frame_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BYTES = 9,
  parameter int HEADER_EN = 1,
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic                    uart_tx,
  output logic                    busy,
  output logic                    frame_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BYTES + 1) + 1;
  localparam int DW = 8 * DATA_BYTES;
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BYTES < 1) begin : g_bad_bytes
    $error("DATA_BYTES must be >= 1");
  end
  if (HEADER_EN != 0 && HEADER_EN != 1) begin : g_bad_hdr
    $error("HEADER_EN must be 0 or 1");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
    $error("PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t r_state, w_state;
  logic [BW-1:0] r_baud;
  logic [2:0] r_bit;
  logic r_stop;
  logic [CW-1:0] r_char;
  logic [DW-1:0] r_buf;
  logic [7:0] r_sh, w_byte;
  logic r_par, r_tx, r_ready, r_busy, r_done;
  logic w_tx, w_ready, w_busy, w_done, w_hs, w_tick, w_next;
  assign w_hs = s_axis_tvalid && r_ready && r_state == IDLE;
  assign w_tick = r_baud == BW'(CLKS_PER_BIT - 1);
  // Character to load: at handshake the header (or top payload byte), afterwards the top of the shift buffer.
  assign w_byte = w_hs ? (HEADER_EN != 0 ? HEADER : s_axis_tdata[DW-1 -: 8]) : r_buf[DW-1 -: 8];
  assign s_axis_tready = r_ready;
  assign uart_tx = r_tx;
  assign busy = r_busy;
  assign frame_done = r_done;
  always_comb begin
    w_state = r_state;
    w_tx = r_tx;
    w_ready = r_ready;
    w_busy = r_busy;
    w_done = 1'b0;
    w_next = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx = 1'b1;
        w_ready = !w_hs;
        w_busy = w_hs;
        if (w_hs) begin
          w_state = START;
          w_tx = 1'b0;
        end
      end
      START: if (w_tick) begin
        w_state = DATA;
        w_tx = r_sh[0];
      end
      DATA: if (w_tick) begin
        if (r_bit != 3'd7) w_tx = r_sh[1];
        else if (PARITY_MODE != 0) begin
          w_state = PARITY;
          w_tx = r_par;
        end else begin
          w_state = STOP;
          w_tx = 1'b1;
        end
      end
      PARITY: if (w_tick) begin
        w_state = STOP;
        w_tx = 1'b1;
      end
      STOP: if (w_tick && r_stop == 1'(STOP_BITS - 1)) begin
        if (r_char == CW'(DATA_BYTES - 1 + HEADER_EN)) begin
          w_state = IDLE;
          w_ready = 1'b1;
          w_busy = 1'b0;
          w_done = 1'b1;
        end else begin
          w_state = START;
          w_tx = 1'b0;
          w_next = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_baud <= '0;
      r_bit <= '0;
      r_stop <= 1'b0;
      r_char <= '0;
      r_tx <= 1'b1;
      r_ready <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state;
      r_tx <= w_tx;
      r_ready <= w_ready;
      r_busy <= w_busy;
      r_done <= w_done;
      r_baud <= (r_state == IDLE || w_state != r_state || w_tick) ? '0 : r_baud + BW'(1);
      r_bit <= w_state != r_state ? '0 : r_bit + 3'(r_state == DATA && w_tick);
      r_stop <= w_state != r_state ? 1'b0 : r_stop ^ (r_state == STOP && w_tick);
      r_char <= r_state == IDLE ? '0 : r_char + CW'(w_next);
    end
  end
  // Payload buffer shifts up one byte per character; the active character shifts right, LSB on the line.
  always_ff @(posedge aclk) begin
    if (w_hs) r_buf <= HEADER_EN != 0 ? s_axis_tdata : s_axis_tdata << 8;
    else if (w_next) r_buf <= r_buf << 8;
    if (w_hs || w_next) begin
      r_sh <= w_byte;
      r_par <= ^w_byte ^ (PARITY_MODE == 2);
    end else if (r_state == DATA && w_tick) r_sh <= r_sh >> 1;
  end
endmodule

// File: tb/tb_axis_uart_frame_tx.sv
// tb_axis_uart_frame_tx: scoreboard bench driving four differently configured transmitters and checking their line waveforms.
module tb_axis_uart_frame_tx;
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic rn [4];
  logic tv [4];
  logic [71:0] td [4];
  logic [3:0] rdy, tx, bsy, done;
  int cfg_cpb [4] = '{4, 3, 3, 868};
  int cfg_nb [4] = '{2, 1, 1, 9};
  int cfg_hdr [4] = '{1, 0, 0, 1};
  int cfg_par [4] = '{0, 1, 2, 0};
  int cfg_stop [4] = '{1, 2, 2, 1};
  int errors = 0;
  int checks = 0;
  logic [71:0] q [4][$];
  logic [71:0] cur [4];
  bit rec [4];
  int idx [4], bad [4], gap [4], lastgap [4], ndone [4];

  axis_uart_frame_tx #(.CLKS_PER_BIT(4), .DATA_BYTES(2), .HEADER_EN(1), .HEADER(8'hA5), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
    .aclk(aclk), .aresetn(rn[0]), .s_axis_tdata(td[0][15:0]), .s_axis_tvalid(tv[0]), .s_axis_tready(rdy[0]),
    .uart_tx(tx[0]), .busy(bsy[0]), .frame_done(done[0]));
  axis_uart_frame_tx #(.CLKS_PER_BIT(3), .DATA_BYTES(1), .HEADER_EN(0), .HEADER(8'hA5), .PARITY_MODE(1), .STOP_BITS(2)) u_b (
    .aclk(aclk), .aresetn(rn[1]), .s_axis_tdata(td[1][7:0]), .s_axis_tvalid(tv[1]), .s_axis_tready(rdy[1]),
    .uart_tx(tx[1]), .busy(bsy[1]), .frame_done(done[1]));
  axis_uart_frame_tx #(.CLKS_PER_BIT(3), .DATA_BYTES(1), .HEADER_EN(0), .HEADER(8'hA5), .PARITY_MODE(2), .STOP_BITS(2)) u_c (
    .aclk(aclk), .aresetn(rn[2]), .s_axis_tdata(td[2][7:0]), .s_axis_tvalid(tv[2]), .s_axis_tready(rdy[2]),
    .uart_tx(tx[2]), .busy(bsy[2]), .frame_done(done[2]));
  axis_uart_frame_tx u_d (
    .aclk(aclk), .aresetn(rn[3]), .s_axis_tdata(td[3]), .s_axis_tvalid(tv[3]), .s_axis_tready(rdy[3]),
    .uart_tx(tx[3]), .busy(bsy[3]), .frame_done(done[3]));

  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  function automatic int clen(input int i);
    return 10 + (cfg_par[i] != 0 ? 1 : 0) + cfg_stop[i] - 1;
  endfunction

  function automatic int flen(input int i);
    return (cfg_nb[i] + cfg_hdr[i]) * clen(i) * cfg_cpb[i];
  endfunction

  // Expected line level idx cycles after the start bit of a frame carrying d.
  function automatic logic exp_bit(input logic [71:0] d, input int i, input int n);
    int cc, ch, b;
    logic [71:0] s;
    logic [7:0] by;
    cc = clen(i) * cfg_cpb[i];
    ch = n / cc;
    b = (n % cc) / cfg_cpb[i];
    s = d >> (8 * (cfg_nb[i] - 1 - ch + cfg_hdr[i]));
    by = (cfg_hdr[i] == 1 && ch == 0) ? 8'hA5 : s[7:0];
    if (b == 0) return 1'b0;
    if (b <= 8) return by[b-1];
    if (b == 9 && cfg_par[i] != 0) return (^by) ^ (cfg_par[i] == 2);
    return 1'b1;
  endfunction

  function automatic logic [71:0] rnd();
    return 72'({$urandom, $urandom, $urandom});
  endfunction

  always @(posedge aclk)
    for (int i = 0; i < 4; i++)
      if (!rn[i]) q[i].delete();
      else if (tv[i] && rdy[i]) q[i].push_back(td[i]);

  always @(negedge aclk)
    for (int i = 0; i < 4; i++) begin
      if (!rn[i]) begin
        rec[i] = 0;
        gap[i] = 0;
      end else if (done[i]) begin
        chk($sformatf("done_has_frame[%0d]", i), rec[i], 1);
        if (rec[i]) begin
          chk($sformatf("frame_len[%0d]", i), idx[i], flen(i));
          chk($sformatf("frame_bits_bad[%0d]", i), bad[i], 0);
        end
        chk($sformatf("ready_at_done[%0d]", i), rdy[i], 1);
        chk($sformatf("busy_at_done[%0d]", i), bsy[i], 0);
        rec[i] = 0;
        ndone[i]++;
        gap[i] = 1;
      end else begin
        if (!rec[i] && tx[i] == 1'b0) begin
          chk($sformatf("start_has_expect[%0d]", i), q[i].size() != 0, 1);
          if (q[i].size() != 0) begin
            cur[i] = q[i].pop_front();
            rec[i] = 1;
            idx[i] = 0;
            bad[i] = 0;
            lastgap[i] = gap[i];
          end
        end
        if (rec[i]) begin
          if (idx[i] >= flen(i) || tx[i] !== exp_bit(cur[i], i, idx[i]) || rdy[i] || !bsy[i]) bad[i]++;
          idx[i]++;
        end else gap[i]++;
      end
    end

  task automatic send(input int i, input logic [71:0] d, input bit hold);
    int n = 0;
    @(negedge aclk);
    td[i] = d;
    tv[i] = 1'b1;
    while (!rdy[i] && n < 100000) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 100000) chk($sformatf("handshake_timeout[%0d]", i), n, 0);
    @(posedge aclk);
    if (!hold) begin
      @(negedge aclk);
      tv[i] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while ((rec[i] || q[i].size() != 0 || !rdy[i]) && n < 100000) begin
      @(negedge aclk);
      #1;
      n++;
    end
    if (n >= 100000) chk($sformatf("idle_timeout[%0d]", i), n, 0);
  endtask

  task automatic run_a();
    int n0;
    send(0, 72'h1234, 0);
    wait_idle(0);
    chk("a_frames_after_1234", ndone[0], 1);
    for (int f = 0; f < 3; f++) begin
      send(0, rnd(), 1);
      @(negedge aclk);
      #1;
      if (f > 0) chk($sformatf("b2b_gap[%0d]", f), lastgap[0], 1);
      repeat (30) @(negedge aclk);
      td[0] = rnd();
    end
    tv[0] = 1'b0;
    wait_idle(0);
    chk("a_frames_after_b2b", ndone[0], 4);
    for (int f = 0; f < 6; f++) begin
      send(0, rnd(), 0);
      repeat ($urandom_range(0, 5)) @(negedge aclk);
    end
    wait_idle(0);
    chk("a_frames_after_random", ndone[0], 10);
    n0 = ndone[0];
    send(0, rnd(), 0);
    repeat (60) @(negedge aclk);
    rn[0] = 1'b0;
    @(posedge aclk);
    #1;
    chk("abort_tx", tx[0], 1);
    chk("abort_ready", rdy[0], 0);
    chk("abort_busy", bsy[0], 0);
    @(negedge aclk);
    #1;
    rn[0] = 1'b1;
    @(posedge aclk);
    #1;
    chk("abort_ready_after_release", rdy[0], 1);
    repeat (200) @(negedge aclk);
    chk("abort_no_done", ndone[0], n0);
  endtask

  task automatic run_bc(input int i);
    send(i, 72'h07, 0);
    wait_idle(i);
    chk($sformatf("frames_after_07[%0d]", i), ndone[i], 1);
    for (int f = 0; f < 4; f++) begin
      send(i, rnd(), 0);
      repeat ($urandom_range(0, 3)) @(negedge aclk);
    end
    wait_idle(i);
    chk($sformatf("frames_total[%0d]", i), ndone[i], 5);
  endtask

  initial begin
    int viol = 0;
    for (int i = 0; i < 4; i++) begin
      rn[i] = 1'b0;
      tv[i] = 1'b0;
      td[i] = '0;
    end
    repeat (3) @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx[%0d]", i), tx[i], 1);
      chk($sformatf("rst_ready[%0d]", i), rdy[i], 0);
      chk($sformatf("rst_busy[%0d]", i), bsy[i], 0);
      chk($sformatf("rst_done[%0d]", i), done[i], 0);
    end
    @(negedge aclk);
    #1;
    for (int i = 0; i < 4; i++) rn[i] = 1'b1;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("ready_after_rst[%0d]", i), rdy[i], 1);
    repeat (50) begin
      @(negedge aclk);
      for (int i = 0; i < 4; i++) if (!rdy[i] || !tx[i] || bsy[i] || done[i]) viol++;
    end
    chk("idle_50_violations", viol, 0);
    fork
      run_a();
      run_bc(1);
      run_bc(2);
      begin
        send(3, rnd(), 0);
        wait_idle(3);
        chk("default_frames", ndone[3], 1);
      end
    join
    for (int i = 0; i < 4; i++) chk($sformatf("queue_empty[%0d]", i), q[i].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
